// File: rtl/dm_responder.sv
// Data-memory responder: combinational-read word RAM plus an optional MMIO window
// (cycle counter, LED register, byte TX FIFO), enabled by defining DM_MMIO_EN.
module dm_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic        inclk,
  input  logic        rstn,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] i_DM_addr,
  input  logic [31:0] i_DM_wdata,
  output logic [31:0] o_DM_rdata,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [15:0] o_led
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic          rd_acc;
  logic          wr_acc;
  logic          mmio_hit;
  logic [AW-1:0] word_idx;
  logic [31:0]   mmio_rdata;
  logic [31:0]   ram_q [DEPTH_WORDS];
  logic          unused_sigs;

  assign rd_acc      = DM_CS && DM_R;
  assign wr_acc      = DM_CS && DM_W;
  assign word_idx    = i_DM_addr[AW+1:2];
  assign unused_sigs = ^{i_DM_addr, i_tx_ready};

  // RAM contents survive reset, so this block has no reset branch.
  always_ff @(posedge inclk) begin
    if (wr_acc && !mmio_hit) begin
      ram_q[word_idx] <= i_DM_wdata;
    end
  end

  always_comb begin
    o_DM_rdata = '0;
    if (rd_acc) begin
      o_DM_rdata = mmio_hit ? mmio_rdata : ram_q[word_idx];
    end
  end

`ifdef DM_MMIO_EN
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [5:0] {
    OFF_CYCLE  = 6'h00,
    OFF_LED    = 6'h01,
    OFF_TXDATA = 6'h02,
    OFF_TXSTAT = 6'h03,
    OFF_DROPS  = 6'h04
  } mmio_reg_e;

  logic [31:0]   cycle_q;
  logic [31:0]   drops_q;
  logic [15:0]   led_q;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [5:0]    reg_sel;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push_req;
  logic          push_ok;

  assign mmio_hit   = (i_DM_addr[31:8] == MMIO_BASE[31:8]);
  assign reg_sel    = i_DM_addr[7:2];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && i_tx_ready;
  assign push_req   = wr_acc && mmio_hit && (reg_sel == OFF_TXDATA);
  // A full FIFO still takes a push when the sink frees a slot on the same edge.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_comb begin
    mmio_rdata = '0;
    case (reg_sel)
      OFF_CYCLE:  mmio_rdata = cycle_q;
      OFF_LED:    mmio_rdata = {16'h0, led_q};
      OFF_TXSTAT: mmio_rdata = {20'h0, 4'(count_q), 6'h0, fifo_empty, fifo_full};
      OFF_DROPS:  mmio_rdata = drops_q;
      default:    mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge inclk or negedge rstn) begin
    if (!rstn) begin
      cycle_q  <= '0;
      led_q    <= '0;
      drops_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fifo_q   <= '{default: '0};
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (wr_acc && mmio_hit && (reg_sel == OFF_LED)) begin
        led_q <= i_DM_wdata[15:0];
      end
      if (push_req && !push_ok && (drops_q != '1)) begin
        drops_q <= drops_q + 32'd1;
      end
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= i_DM_wdata[7:0];
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign o_tx_valid = !fifo_empty;
  assign o_tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign o_led      = led_q;
`else
  assign mmio_hit   = 1'b0;
  assign mmio_rdata = '0;
  assign o_tx_valid = 1'b0;
  assign o_tx_data  = '0;
  assign o_led      = '0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed vector table, hand-written MMIO
// sequences (when DM_MMIO_EN is defined) and a randomized run against a reference model.
module tb_dm_responder;

  logic        inclk = 1'b0;
  logic        rstn  = 1'b0;
  logic        DM_CS = 1'b0;
  logic        DM_R  = 1'b0;
  logic        DM_W  = 1'b0;
  logic [31:0] i_DM_addr  = '0;
  logic [31:0] i_DM_wdata = '0;
  logic [31:0] o_DM_rdata;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b0;
  logic [15:0] o_led;

  int unsigned tests = 0;
  int unsigned fails = 0;

`ifdef DM_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  dm_responder #(
    .DEPTH_WORDS(1024),
    .FIFO_DEPTH (8),
    .MMIO_BASE  (32'hFFFF_FF00)
  ) dut (
    .inclk     (inclk),
    .rstn      (rstn),
    .DM_CS     (DM_CS),
    .DM_R      (DM_R),
    .DM_W      (DM_W),
    .i_DM_addr (i_DM_addr),
    .i_DM_wdata(i_DM_wdata),
    .o_DM_rdata(o_DM_rdata),
    .o_tx_data (o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_led     (o_led)
  );

  always #5 inclk = ~inclk;

  // Reference cycle count: edges seen since reset was released.
  logic [31:0] cyc_m;
  always @(posedge inclk or negedge rstn) begin
    if (!rstn) cyc_m <= '0;
    else       cyc_m <= cyc_m + 32'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    DM_CS = cs; DM_R = r; DM_W = w; i_DM_addr = a; i_DM_wdata = d;
  endtask

  task automatic mmio_read(input string name, input logic [7:0] off, input logic [31:0] exp);
    @(negedge inclk);
    drive(1'b1, 1'b1, 1'b0, {24'hFFFFFF, off}, '0);
    #1 chk(name, o_DM_rdata, exp);
  endtask

  task automatic mmio_write(input logic [7:0] off, input logic [31:0] d);
    @(negedge inclk);
    drive(1'b1, 1'b0, 1'b1, {24'hFFFFFF, off}, d);
  endtask

  typedef struct {
    string       name;
    logic        cs, r, w;
    logic [31:0] addr, wdata;
    logic        check;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input string n, input logic cs, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic c, input logic [31:0] e);
    vec_t v;
    v.name = n; v.cs = cs; v.r = r; v.w = w; v.addr = a; v.wdata = d; v.check = c; v.exp = e;
    vt.push_back(v);
  endfunction

  // Behavioural model state for the random phase.
  logic [31:0] ram_m [int unsigned];
  logic [7:0]  q_m [$];
  logic [15:0] led_m;
  logic [31:0] drops_m;

  initial begin
    logic [7:0] off_tab [8];
    logic [9:0] key_pool [8];

    add("ram_wr10",     1, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);
    add("ram_rd10",     1, 1, 0, 32'h0000_0010, 0,             1, 32'hDEAD_BEEF);
    add("ram_alias",    1, 1, 0, 32'h0000_1010, 0,             1, 32'hDEAD_BEEF);
    add("rd_no_cs",     0, 1, 0, 32'h0000_0010, 0,             1, 32'h0);
    add("no_strobe",    1, 0, 0, 32'h0000_0010, 0,             1, 32'h0);
    add("rw_pre_edge",  1, 1, 1, 32'h0000_0010, 32'h1111_2222, 1, 32'hDEAD_BEEF);
    add("rw_post_edge", 1, 1, 0, 32'h0000_0010, 0,             1, 32'h1111_2222);
    add("ram_wr20",     1, 0, 1, 32'h0000_0020, 32'h1234_5678, 0, 0);
    add("wr_no_cs",     0, 0, 1, 32'h0000_0020, 32'hAAAA_5555, 0, 0);
    add("wr_no_cs_rd",  1, 1, 0, 32'h0000_0020, 0,             1, 32'h1234_5678);
    add("byte_bits",    1, 1, 0, 32'h0000_0013, 0,             1, 32'h1111_2222);
    add("ram_wr_top",   1, 0, 1, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 0);
    add("ram_rd_top",   1, 1, 0, 32'h0000_7FFC, 0,             1, 32'hCAFE_F00D);
    add("upper_alias",  1, 1, 0, 32'hFFFF_0010, 0,             1, 32'h1111_2222);
    add("ram_wr40",     1, 0, 1, 32'h0000_0040, 32'h0BAD_F00D, 0, 0);

    // Reset state
    @(negedge inclk);
    #1;
    chk("rst_rdata", o_DM_rdata, 32'h0);
    chk("rst_valid", {31'h0, o_tx_valid}, 32'h0);
    chk("rst_txdata", {24'h0, o_tx_data}, 32'h0);
    chk("rst_led", {16'h0, o_led}, 32'h0);

    @(negedge inclk);
    rstn = 1'b1;
    repeat (5) @(posedge inclk);
    if (MMIO_ON) mmio_read("cycle_5", 8'h00, 32'd5);

    foreach (vt[i]) begin
      @(negedge inclk);
      drive(vt[i].cs, vt[i].r, vt[i].w, vt[i].addr, vt[i].wdata);
      #1;
      if (vt[i].check) chk(vt[i].name, o_DM_rdata, vt[i].exp);
    end

`ifdef DM_MMIO_EN
    mmio_write(8'h04, 32'h1234_ABCD);
    @(negedge inclk);
    drive(0, 0, 0, '0, '0);
    #1 chk("led_out", {16'h0, o_led}, 32'h0000_ABCD);
    mmio_read("led_rd", 8'h04, 32'h0000_ABCD);
    mmio_write(8'h00, 32'hFFFF_FFFF);
    mmio_read("txdata_rd0", 8'h08, 32'h0);
    mmio_read("other_off", 8'h20, 32'h0);

    i_tx_ready = 1'b0;
    for (int k = 1; k <= 10; k++) mmio_write(8'h08, 32'(k) | 32'hFFFF_FF00);
    mmio_read("fill_stat", 8'h0C, 32'h0000_0801);
    mmio_read("fill_drops", 8'h10, 32'd2);
    chk("fill_head", {24'h0, o_tx_data}, 32'h01);

    for (int k = 1; k <= 8; k++) begin
      @(negedge inclk);
      drive(0, 0, 0, '0, '0);
      i_tx_ready = 1'b1;
      #1;
      chk("drain_valid", {31'h0, o_tx_valid}, 32'h1);
      chk("drain_data", {24'h0, o_tx_data}, 32'(k));
    end
    @(negedge inclk);
    #1 chk("drained_valid", {31'h0, o_tx_valid}, 32'h0);
    chk("drained_data", {24'h0, o_tx_data}, 32'h0);
    mmio_read("drained_stat", 8'h0C, 32'h0000_0002);

    i_tx_ready = 1'b0;
    for (int k = 0; k < 8; k++) mmio_write(8'h08, 32'h20 + 32'(k));
    mmio_write(8'h08, 32'h55);
    i_tx_ready = 1'b1;
    #1 chk("full_head", {24'h0, o_tx_data}, 32'h20);
    @(negedge inclk);
    i_tx_ready = 1'b0;
    drive(1, 1, 0, 32'hFFFF_FF0C, '0);
    #1 chk("full_pushpop_stat", o_DM_rdata, 32'h0000_0801);
    chk("full_pushpop_head", {24'h0, o_tx_data}, 32'h21);
    mmio_read("full_pushpop_drops", 8'h10, 32'd2);

    for (int k = 0; k < 5; k++) begin
      @(negedge inclk);
      drive(0, 0, 0, '0, '0);
      i_tx_ready = 1'b1;
    end
    @(negedge inclk);
    i_tx_ready = 1'b0;
    #1 chk("pre_rst_head", {24'h0, o_tx_data}, 32'h26);
    mmio_read("pre_rst_stat", 8'h0C, 32'h0000_0300);
`endif

    // Asynchronous reset in the middle of a cycle
    @(negedge inclk);
    drive(0, 0, 0, '0, '0);
    #1 rstn = 1'b0;
    #1;
    chk("arst_valid", {31'h0, o_tx_valid}, 32'h0);
    chk("arst_txdata", {24'h0, o_tx_data}, 32'h0);
    chk("arst_led", {16'h0, o_led}, 32'h0);
    if (MMIO_ON) begin
      drive(1, 1, 0, 32'hFFFF_FF00, '0);
      #1 chk("arst_cycle", o_DM_rdata, 32'h0);
      drive(1, 1, 0, 32'hFFFF_FF10, '0);
      #1 chk("arst_drops", o_DM_rdata, 32'h0);
    end
    @(negedge inclk);
    drive(1, 1, 0, 32'h0000_0040, '0);
    #1 chk("arst_ram_keep", o_DM_rdata, 32'h0BAD_F00D);

`ifndef DM_MMIO_EN
    @(negedge inclk);
    rstn = 1'b1;
    drive(1, 0, 1, 32'hFFFF_FF04, 32'h5A5A_0001);
    i_tx_ready = 1'b1;
    @(negedge inclk);
    drive(1, 1, 0, 32'h0000_0F04, '0);
    #1 chk("nommio_ram", o_DM_rdata, 32'h5A5A_0001);
    chk("nommio_led", {16'h0, o_led}, 32'h0);
    chk("nommio_valid", {31'h0, o_tx_valid}, 32'h0);
`endif

    // Random phase against the reference model
    @(negedge inclk);
    drive(0, 0, 0, '0, '0);
    rstn = 1'b1;
    ram_m.delete();
    q_m.delete();
    led_m = '0;
    drops_m = '0;
    off_tab = '{8'h00, 8'h04, 8'h08, 8'h08, 8'h08, 8'h0C, 8'h10, 8'h08};
    key_pool = '{10'h000, 10'h001, 10'h002, 10'h005, 10'h100, 10'h200, 10'h3FE, 10'h3C1};

    for (int n = 0; n < 600; n++) begin
      logic        cs, r, w, rdy, hit, known, is_rd, is_wr, pop;
      logic [31:0] a, d, exp;
      logic [7:0]  off;
      logic [9:0]  key;
      int unsigned sel;

      @(negedge inclk);
      cs  = ($urandom_range(0, 9) != 0);
      r   = $urandom_range(0, 1) == 1;
      w   = $urandom_range(0, 1) == 1;
      d   = $urandom;
      rdy = (n < 300) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        off = (sel == 5) ? 8'($urandom) : off_tab[$urandom_range(0, 7)] | 8'($urandom_range(0, 3));
        a = {24'hFFFFFF, off};
      end else begin
        a = $urandom;
        if (a[31:8] == 24'hFFFFFF) a[31] = 1'b0;
        a[11:2] = key_pool[$urandom_range(0, 7)];
      end
      drive(cs, r, w, a, d);
      i_tx_ready = rdy;
      #1;

      is_rd = cs && r;
      is_wr = cs && w;
      hit   = MMIO_ON && (a[31:8] == 24'hFFFFFF);
      key   = a[11:2];
      exp   = '0;
      known = 1'b1;
      if (is_rd) begin
        if (hit) begin
          case (a[7:0] & 8'hFC)
            8'h00: exp = cyc_m;
            8'h04: exp = {16'h0, led_m};
            8'h0C: exp = (32'(q_m.size()) << 8) | (q_m.size() == 0 ? 32'h2 : 32'h0)
                         | (q_m.size() == 8 ? 32'h1 : 32'h0);
            8'h10: exp = drops_m;
            default: exp = '0;
          endcase
        end else if (ram_m.exists(32'(key))) begin
          exp = ram_m[32'(key)];
        end else begin
          known = 1'b0;
        end
      end
      if (known) chk("rand_rdata", o_DM_rdata, exp);
      chk("rand_valid", {31'h0, o_tx_valid}, {31'h0, q_m.size() != 0});
      chk("rand_txdata", {24'h0, o_tx_data}, (q_m.size() != 0) ? {24'h0, q_m[0]} : 32'h0);
      chk("rand_led", {16'h0, o_led}, {16'h0, led_m});

      pop = MMIO_ON && (q_m.size() != 0) && rdy;
      if (is_wr && !hit) ram_m[32'(key)] = d;
      if (is_wr && hit && (a[7:0] & 8'hFC) == 8'h04) led_m = d[15:0];
      if (pop) void'(q_m.pop_front());
      if (is_wr && hit && (a[7:0] & 8'hFC) == 8'h08) begin
        if (q_m.size() < 8) q_m.push_back(d[7:0]);
        else if (drops_m != 32'hFFFF_FFFF) drops_m++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
